// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// op and state encodings, operand width, iteration count, magnitude helper.
package muldiv_pkg;
  localparam int XLEN  = 32;
  localparam int STEPS = 32;
  localparam int CNT_W = $clog2(STEPS);

  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_DIVU  = 2'd1,
    OP_MULT  = 2'd2,
    OP_DIV   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIX   = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Two's-complement negate when neg is set (absolute value / sign restore).
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction
endpackage

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side bundle for the mul/div sequencer: issue, flush, HI/LO
// hazard inputs and the busy/stall/done/HI/LO outputs.
interface muldiv_sequencer_if;
  import muldiv_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            hi_used;
  logic            lo_used;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush, hi_used, lo_used,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hi_used, lo_used,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// Iteration datapath: 64-bit shift register plus one 33-bit add/subtract.
// Multiply: {product_hi, multiplier} shifts right, adding the multiplicand
// into the upper half when the current multiplier LSB is 1.
// Divide (restoring): {remainder, quotient} shifts left, subtracting the
// divisor when it fits and shifting a 1 into the quotient. A zero divisor
// always "fits", which naturally yields quotient all-ones and remainder =
// dividend.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_acc
);
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [XLEN+1:0]   w_as;
  logic              w_fits;
  logic [2*XLEN-1:0] w_nxt;

  // One shared adder; the divide path compares the shifted-in 33-bit
  // partial remainder against the divisor, the multiply path accumulates.
  always_comb begin
    w_as   = i_is_div ? ({1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b0, r_b})
                      : ({2'b0, r_acc[2*XLEN-1:XLEN]}   + {2'b0, r_b});
    w_fits = ~w_as[XLEN+1];
    if (i_is_div)
      w_nxt = w_fits ? {w_as[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                     : {r_acc[2*XLEN-2:0], 1'b0};
    else
      w_nxt = r_acc[0] ? {w_as[XLEN:0], r_acc[XLEN-1:1]}
                       : {1'b0, r_acc[2*XLEN-1:1]};
  end

  // Load operands on issue, then advance one step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_acc <= {{XLEN{1'b0}}, i_a};
      r_b   <= i_b;
    end else if (i_step) begin
      r_acc <= w_nxt;
    end
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multi-cycle mul/div sequencer: FSM, step counter, stall generation,
// sign handling and the architectural HI/LO registers.
// Optional signed MULT/DIV support is compiled in with `define MULDIV_SIGNED_EN.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_sequencer_if.slave  bus
);
  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_div;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;

  logic              w_load;
  logic              w_step;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [2*XLEN-1:0] w_acc;
  logic [2*XLEN-1:0] w_res;

  assign w_load = (r_state == ST_IDLE) & bus.start & ~bus.flush;
  assign w_step = (r_state == ST_RUN);

`ifdef MULDIV_SIGNED_EN
  logic              r_sgn;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [2*XLEN-1:0] r_fix;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [2*XLEN-1:0] w_fix;

  assign w_a_neg = bus.op[1] & bus.src_a[XLEN-1];
  assign w_b_neg = bus.op[1] & bus.src_b[XLEN-1];
  assign w_a_mag = cond_neg(bus.src_a, w_a_neg);
  assign w_b_mag = cond_neg(bus.src_b, w_b_neg);

  // Sign restore: product as a whole, quotient by sign difference,
  // remainder follows the dividend.
  always_comb begin
    if (r_is_div)
      w_fix = {cond_neg(w_acc[2*XLEN-1:XLEN], r_neg_r), cond_neg(w_acc[XLEN-1:0], r_neg_q)};
    else
      w_fix = r_neg_q ? (~w_acc + 1'b1) : w_acc;
  end

  assign w_res = r_sgn ? r_fix : w_acc;
`else
  assign w_a_mag = bus.src_a;
  assign w_b_mag = bus.src_b;
  assign w_res   = w_acc;
`endif

  muldiv_iter_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (r_is_div),
    .i_a      (w_a_mag),
    .i_b      (w_b_mag),
    .o_acc    (w_acc)
  );

  // Sequencer FSM with registered busy/done and the HI/LO commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef MULDIV_SIGNED_EN
      r_sgn    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_fix    <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state  <= ST_RUN;
            r_cnt    <= CNT_W'(STEPS - 1);
            r_is_div <= bus.op[0];
            r_busy   <= 1'b1;
`ifdef MULDIV_SIGNED_EN
            r_sgn    <= bus.op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
`endif
          end
        end
        ST_RUN: begin
          if (bus.flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
`ifdef MULDIV_SIGNED_EN
            if (r_sgn) begin
              r_state <= ST_FIX;
            end else begin
              r_state <= ST_WRITE;
              r_done  <= 1'b1;
            end
`else
            r_state <= ST_WRITE;
            r_done  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef MULDIV_SIGNED_EN
        ST_FIX: begin
          if (bus.flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_fix   <= w_fix;
            r_state <= ST_WRITE;
            r_done  <= 1'b1;
          end
        end
`endif
        ST_WRITE: begin
          // Flush is deliberately ignored here: the result is architectural.
          r_hi    <= w_res[2*XLEN-1:XLEN];
          r_lo    <= w_res[XLEN-1:0];
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.stall = r_busy & (bus.start | bus.hi_used | bus.lo_used);
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + randomized bench for muldiv_sequencer against an arithmetic
// reference model. Honors MULDIV_SIGNED_EN the same way the design does.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; signed ops sign-extend operands.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic   sgn;
    longint sa, sb;
    logic [31:0] q, r;
    sgn = SIGNED && op[1];
    sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!op[0]) return 64'(sa * sb);
    if (b == 32'd0) begin
      r = a;
      q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
    return {r, q};
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge (k = 0).
  task automatic wait_result(input string tag, input logic [63:0] exp,
                             input logic [1:0] op, input bit chk_stall);
    int lat, dn, dk, ik, bad;
    lat = (SIGNED && op[1]) ? 33 : 32;
    dn = 0; dk = -1; ik = -1; bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (chk_stall && (bus.stall !== bus.busy)) bad++;
      if (bus.done === 1'b1) begin dn++; dk = k; end
      if (bus.busy === 1'b0) begin ik = k; break; end
      @(negedge clk);
    end
    chk({tag, " done_cycle"}, 64'(dk), 64'(lat));
    chk({tag, " done_pulses"}, 64'(dn), 64'd1);
    chk({tag, " idle_cycle"}, 64'(ik), 64'(lat + 1));
    chk({tag, " hi"}, {32'b0, bus.hi}, {32'b0, exp[63:32]});
    chk({tag, " lo"}, {32'b0, bus.lo}, {32'b0, exp[31:0]});
    if (chk_stall) chk({tag, " stall_track"}, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int dn, chg, seen;
    bus.start = 1'b0; bus.op = 2'd0; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.hi_used = 1'b0; bus.lo_used = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy",  {63'b0, bus.busy},  64'd0);
    chk("rst stall", {63'b0, bus.stall}, 64'd0);
    chk("rst done",  {63'b0, bus.done},  64'd0);
    chk("rst hi",    {32'b0, bus.hi},    64'd0);
    chk("rst lo",    {32'b0, bus.lo},    64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu busy_after_issue", {63'b0, bus.busy}, 64'd1);
    wait_result("multu_max", 64'hFFFF_FFFE_0000_0001, 2'd0, 1'b0);

    issue(2'd1, 32'd100, 32'd7);
    wait_result("divu_100_7", {32'd2, 32'd14}, 2'd1, 1'b0);

    issue(2'd1, 32'h1234_5678, 32'd0);
    wait_result("divu_by0", {32'h1234_5678, 32'hFFFF_FFFF}, 2'd1, 1'b0);

    // MFLO waiting behind a DIVU: stall must track busy through WRITE.
    issue(2'd1, 32'd1000, 32'd10);
    bus.lo_used = 1'b1;
    wait_result("lo_used", {32'd0, 32'd100}, 2'd1, 1'b1);
    bus.lo_used = 1'b0;

    // Flush at RUN step 10: no commit, no done.
    issue(2'd0, 32'h0001_0001, 32'd3);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_run busy", {63'b0, bus.busy}, 64'd0);
    dn = 0; chg = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) dn++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd100) chg++;
      @(negedge clk);
    end
    chk("flush_run done", 64'(dn), 64'd0);
    chk("flush_run hilo_kept", 64'(chg), 64'd0);

    // Start together with flush in IDLE is dropped.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'd0; bus.src_a = 32'd5; bus.src_b = 32'd5;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start busy", {63'b0, bus.busy}, 64'd0);

    // Back-to-back: second start held (re-presented) while busy.
    issue(2'd0, 32'h0000_1234, 32'h0000_5678);
    bus.start = 1'b1; bus.op = 2'd1; bus.src_a = 32'hDEAD_BEEF; bus.src_b = 32'h0000_1000;
    wait_result("b2b_first", model(2'd0, 32'h0000_1234, 32'h0000_5678), 2'd0, 1'b1);
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    chk("b2b second_accepted", {63'b0, bus.busy}, 64'd1);
    wait_result("b2b_second", model(2'd1, 32'hDEAD_BEEF, 32'h0000_1000), 2'd1, 1'b0);

    // Flush during WRITE is ignored.
    issue(2'd1, 32'd1000003, 32'd1000);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.done === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("flush_write reached", 64'(seen), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_write busy", {63'b0, bus.busy}, 64'd0);
    chk("flush_write hi", {32'b0, bus.hi}, {32'b0, 32'd3});
    chk("flush_write lo", {32'b0, bus.lo}, {32'b0, 32'd1000});

`ifdef MULDIV_SIGNED_EN
    issue(2'd3, 32'hFFFF_FFF9, 32'd2);
    wait_result("div_m7_2", 64'hFFFF_FFFF_FFFF_FFFD, 2'd3, 1'b0);
    issue(2'd2, 32'hFFFF_FFFD, 32'd5);
    wait_result("mult_m3_5", 64'hFFFF_FFFF_FFFF_FFF1, 2'd2, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
      issue(rop, ra, rb);
      wait_result($sformatf("rand%0d op%0d", i, rop), model(rop, ra, rb), rop, 1'b0);
    end

    // Async reset in the middle of RUN clears everything at once.
    issue(2'd0, 32'd3, 32'd5);
    wait_result("pre_reset", {32'd0, 32'd15}, 2'd0, 1'b0);
    issue(2'd0, 32'd7, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", {63'b0, bus.busy}, 64'd0);
    chk("midrst done", {63'b0, bus.done}, 64'd0);
    chk("midrst hi",   {32'b0, bus.hi},   64'd0);
    chk("midrst lo",   {32'b0, bus.lo},   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst busy", {63'b0, bus.busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
